accumulator_unit: RTL and testbench

Registered, parametrised accumulator datapath for the Mano-style CPU. It holds AC and the carry/extend flag E, and executes register-reference and memory-reference arithmetic on an encoded opcode with a start/busy/done handshake. It adds multi-cycle rotate-by-N operations, so the control sequencer can issue a rotate once instead of once per bit. It sits between the DR/INPR registers and the control unit, replacing a purely combinational ALU plus external AC/E registers.

---
 rtl/accumulator_unit.sv | 142 ++++++++++++++
 tb/tb_accumulator_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_unit.sv
// AC/E accumulator datapath with single-cycle ALU ops and multi-cycle rotate-by-N through E.
// Optional macro ACCUMULATOR_FLAGS_EN adds ac_zero_out / ac_neg_out decoded from AC.
module accumulator_unit #(
   parameter int WIDTH      = 16,
   parameter int INPR_WIDTH = 8
) (
   input  logic                    clk_in,
   input  logic                    reset_in,
   input  logic [WIDTH-1:0]        dr_in,
   input  logic [INPR_WIDTH-1:0]   inpr_in,
   input  logic [3:0]              op_in,
   input  logic [$clog2(WIDTH):0]  count_in,
   input  logic                    start_in,
   output logic [WIDTH-1:0]        ac_out,
   output logic                    e_out,
   output logic                    busy_out,
   output logic                    done_out
`ifdef ACCUMULATOR_FLAGS_EN
   ,
   output logic                    ac_zero_out,
   output logic                    ac_neg_out
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND   = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_LDA   = 4'd3;
   localparam logic [3:0] OP_INP   = 4'd4;
   localparam logic [3:0] OP_CMA   = 4'd5;
   localparam logic [3:0] OP_CIR   = 4'd6;
   localparam logic [3:0] OP_CIL   = 4'd7;
   localparam logic [3:0] OP_CLA   = 4'd8;
   localparam logic [3:0] OP_CLE   = 4'd9;
   localparam logic [3:0] OP_CME   = 4'd10;
   localparam logic [3:0] OP_INC   = 4'd11;
   localparam logic [3:0] OP_ROR_N = 4'd12;
   localparam logic [3:0] OP_ROL_N = 4'd13;

   typedef enum logic {S_IDLE = 1'b0, S_ROTATE = 1'b1} state_t;

   // Ring is {E, AC}: CIL rotates it left, CIR rotates it right.
   function automatic logic [WIDTH:0] f_rol(input logic [WIDTH:0] v);
      return {v[WIDTH-1:0], v[WIDTH]};
   endfunction

   function automatic logic [WIDTH:0] f_ror(input logic [WIDTH:0] v);
      return {v[0], v[WIDTH:1]};
   endfunction

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_ac, w_ac_nxt;
   logic             r_e, w_e_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_dir, w_dir_nxt;
   logic             r_done, w_done_nxt;
   logic [WIDTH:0]   w_ring;
   logic [WIDTH:0]   w_sum;
   logic             w_accept;

   assign w_ring   = {r_e, r_ac};
   assign w_sum    = {1'b0, r_ac} + {1'b0, dr_in};
   assign w_accept = start_in && (r_state == S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_ac_nxt    = r_ac;
      w_e_nxt     = r_e;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_done_nxt = 1'b1;
               case (op_in)
                  OP_AND: w_ac_nxt = r_ac & dr_in;
                  OP_ADD: {w_e_nxt, w_ac_nxt} = w_sum;
                  OP_LDA: w_ac_nxt = dr_in;
                  OP_INP: w_ac_nxt = WIDTH'(inpr_in);
                  OP_CMA: w_ac_nxt = ~r_ac;
                  OP_CIR: {w_e_nxt, w_ac_nxt} = f_ror(w_ring);
                  OP_CIL: {w_e_nxt, w_ac_nxt} = f_rol(w_ring);
                  OP_CLA: w_ac_nxt = '0;
                  OP_CLE: w_e_nxt = 1'b0;
                  OP_CME: w_e_nxt = ~r_e;
                  OP_INC: w_ac_nxt = r_ac + WIDTH'(1);
                  OP_ROR_N, OP_ROL_N: begin
                     // Zero count degenerates to a single-cycle NOP.
                     if (count_in != '0) begin
                        w_state_nxt = S_ROTATE;
                        w_cnt_nxt   = count_in;
                        w_dir_nxt   = (op_in == OP_ROL_N);
                        w_done_nxt  = 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_ROTATE: begin
            {w_e_nxt, w_ac_nxt} = r_dir ? f_rol(w_ring) : f_ror(w_ring);
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state <= S_IDLE;
         r_ac    <= '0;
         r_e     <= 1'b0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ac    <= w_ac_nxt;
         r_e     <= w_e_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dir   <= w_dir_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign ac_out   = r_ac;
   assign e_out    = r_e;
   assign busy_out = (r_state == S_ROTATE);
   assign done_out = r_done;

`ifdef ACCUMULATOR_FLAGS_EN
   assign ac_zero_out = (r_ac == '0);
   assign ac_neg_out  = r_ac[WIDTH-1];
`endif

endmodule

// File: tb/tb_accumulator_unit.sv
// Bench for accumulator_unit: directed plan scenarios plus random ops against an arithmetic ring model.
module tb_accumulator_unit;

   logic        clk = 1'b0;
   logic        reset_in;
   logic [15:0] dr_in;
   logic [7:0]  inpr_in;
   logic [3:0]  op_in;
   logic [4:0]  count_in;
   logic        start_in;
   logic [15:0] ac_out;
   logic        e_out, busy_out, done_out;

   logic        s_reset;
   logic [7:0]  s_dr;
   logic [3:0]  s_inpr;
   logic [3:0]  s_op;
   logic [3:0]  s_cnt;
   logic        s_start;
   logic [7:0]  s_ac;
   logic        s_e, s_busy, s_done;

`ifdef ACCUMULATOR_FLAGS_EN
   logic        ac_zero_out, ac_neg_out, s_zero, s_neg;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   accumulator_unit #(.WIDTH(16), .INPR_WIDTH(8)) dut (
      .clk_in(clk), .reset_in(reset_in), .dr_in(dr_in), .inpr_in(inpr_in),
      .op_in(op_in), .count_in(count_in), .start_in(start_in),
      .ac_out(ac_out), .e_out(e_out), .busy_out(busy_out), .done_out(done_out)
`ifdef ACCUMULATOR_FLAGS_EN
      , .ac_zero_out(ac_zero_out), .ac_neg_out(ac_neg_out)
`endif
   );

   accumulator_unit #(.WIDTH(8), .INPR_WIDTH(4)) dut_small (
      .clk_in(clk), .reset_in(s_reset), .dr_in(s_dr), .inpr_in(s_inpr),
      .op_in(s_op), .count_in(s_cnt), .start_in(s_start),
      .ac_out(s_ac), .e_out(s_e), .busy_out(s_busy), .done_out(s_done)
`ifdef ACCUMULATOR_FLAGS_EN
      , .ac_zero_out(s_zero), .ac_neg_out(s_neg)
`endif
   );

   // Rotate the 17-bit {E,AC} ring left by n positions using plain arithmetic.
   function automatic logic [16:0] rotl(input logic [16:0] v, input int n);
      logic [31:0] w;
      int k;
      k = ((n % 17) + 17) % 17;
      w = {15'b0, v};
      w = ((w << k) | (w >> (17 - k))) & 32'h1FFFF;
      return w[16:0];
   endfunction

   function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] dr,
                                         input logic [7:0] inpr, input int cnt,
                                         input logic [16:0] v);
      logic [15:0] ac;
      logic        e;
      logic [31:0] w;
      e  = v[16];
      ac = v[15:0];
      case (op)
         4'd1:  ac = ac & dr;
         4'd2:  begin w = {16'b0, ac} + {16'b0, dr}; e = w[16]; ac = w[15:0]; end
         4'd3:  ac = dr;
         4'd4:  ac = {8'h00, inpr};
         4'd5:  ac = ~ac;
         4'd6:  return rotl(v, -1);
         4'd7:  return rotl(v, 1);
         4'd8:  ac = 16'h0000;
         4'd9:  e = 1'b0;
         4'd10: e = ~e;
         4'd11: ac = ac + 16'd1;
         4'd12: return rotl(v, -cnt);
         4'd13: return rotl(v, cnt);
         default: ;
      endcase
      return {e, ac};
   endfunction

   // Drives one command and measures latency to done, busy cycles, and the cycle after done.
   task automatic run_cmd(input logic [3:0] op, input logic [15:0] dr, input logic [7:0] inpr,
                          input logic [4:0] cnt, output int lat, output int busy_n,
                          output logic done_after);
      @(negedge clk);
      op_in = op; dr_in = dr; inpr_in = inpr; count_in = cnt; start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      lat = 1;
      busy_n = 0;
      while (lat < 64 && done_out !== 1'b1) begin
         if (busy_out === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
      if (done_out !== 1'b1) lat = -1;
      else if (busy_out === 1'b1) busy_n++;
      @(negedge clk);
      done_after = done_out;
   endtask

   task automatic s_cmd(input logic [3:0] op, input logic [7:0] dr, input logic [3:0] inpr);
      @(negedge clk);
      s_op = op; s_dr = dr; s_inpr = inpr; s_cnt = '0; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
   endtask

   task automatic test_reset();
      reset_in = 1'b1; s_reset = 1'b1; start_in = 1'b0; s_start = 1'b0;
      op_in = '0; dr_in = '0; inpr_in = '0; count_in = '0;
      s_op = '0; s_dr = '0; s_inpr = '0; s_cnt = '0;
      repeat (3) @(negedge clk);
      reset_in = 1'b0; s_reset = 1'b0;
      total++;
      if ({e_out, ac_out, busy_out, done_out} !== 19'b0) begin
         bad++;
         $display("FAIL reset_state: got e=%b ac=%h busy=%b done=%b want all 0", e_out, ac_out, busy_out, done_out);
      end
`ifdef ACCUMULATOR_FLAGS_EN
      total++;
      if (ac_zero_out !== 1'b1 || ac_neg_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: got zero=%b neg=%b want 1 0", ac_zero_out, ac_neg_out);
      end
`endif
   endtask

   task automatic test_lda_add();
      int lat, bn;
      logic da;
      run_cmd(4'd3, 16'h5678, 8'h00, 5'd0, lat, bn, da);
      total++;
      if ({e_out, ac_out} !== {1'b0, 16'h5678} || lat != 1 || bn != 0 || da !== 1'b0) begin
         bad++;
         $display("FAIL lda: got e=%b ac=%h lat=%0d busy=%0d after=%b want 0 5678 1 0 0", e_out, ac_out, lat, bn, da);
      end
      run_cmd(4'd2, 16'hF234, 8'h00, 5'd0, lat, bn, da);
      total++;
      if ({e_out, ac_out} !== {1'b1, 16'h48AC} || lat != 1) begin
         bad++;
         $display("FAIL add_carry: got e=%b ac=%h lat=%0d want 1 48ac 1", e_out, ac_out, lat);
      end
   endtask

   task automatic test_cir_cil();
      int lat, bn;
      logic da;
      run_cmd(4'd3, 16'h1234, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd9, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd10, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd6, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      total++;
      if ({e_out, ac_out} !== {1'b0, 16'h891A}) begin
         bad++;
         $display("FAIL cir: got e=%b ac=%h want 0 891a", e_out, ac_out);
      end
      run_cmd(4'd7, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      total++;
      if ({e_out, ac_out} !== {1'b1, 16'h1234}) begin
         bad++;
         $display("FAIL cil: got e=%b ac=%h want 1 1234", e_out, ac_out);
      end
   endtask

   task automatic test_rotate_n();
      int lat, bn;
      logic da;
      run_cmd(4'd3, 16'h1234, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd9, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      @(negedge clk);
      op_in = 4'd13; count_in = 5'd4; start_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         start_in = 1'b0;
         total++;
         if (busy_out !== (i <= 4) || done_out !== (i == 5)) begin
            bad++;
            $display("FAIL rol4_timing[%0d]: got busy=%b done=%b want %b %b", i, busy_out, done_out, i <= 4, i == 5);
         end
         if (i == 2) begin
            op_in = 4'd3; dr_in = 16'hFFFF; start_in = 1'b1;
         end
      end
      total++;
      if ({e_out, ac_out} !== {1'b1, 16'h2340}) begin
         bad++;
         $display("FAIL rol4_value: got e=%b ac=%h want 1 2340", e_out, ac_out);
      end
      @(negedge clk);
      total++;
      if (done_out !== 1'b0 || busy_out !== 1'b0) begin
         bad++;
         $display("FAIL rol4_after: got done=%b busy=%b want 0 0", done_out, busy_out);
      end
   endtask

   task automatic test_rotate_wrap();
      int lat, bn;
      logic da;
      run_cmd(4'd3, 16'hBEEF, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd9, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd10, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd12, 16'h0000, 8'h00, 5'd17, lat, bn, da);
      total++;
      if ({e_out, ac_out} !== {1'b1, 16'hBEEF} || lat != 18 || bn != 17 || da !== 1'b0) begin
         bad++;
         $display("FAIL ror17: got e=%b ac=%h lat=%0d busy=%0d after=%b want 1 beef 18 17 0", e_out, ac_out, lat, bn, da);
      end
      run_cmd(4'd12, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      total++;
      if ({e_out, ac_out} !== {1'b1, 16'hBEEF} || lat != 1 || bn != 0) begin
         bad++;
         $display("FAIL ror0: got e=%b ac=%h lat=%0d busy=%0d want 1 beef 1 0", e_out, ac_out, lat, bn);
      end
   endtask

   task automatic test_reset_mid_rotate();
      int lat, bn;
      logic da, seen;
      run_cmd(4'd3, 16'h1234, 8'h00, 5'd0, lat, bn, da);
      @(negedge clk);
      op_in = 4'd13; count_in = 5'd8; start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      repeat (2) @(negedge clk);
      reset_in = 1'b1;
      @(negedge clk);
      reset_in = 1'b0;
      total++;
      if ({e_out, ac_out, busy_out, done_out} !== 19'b0) begin
         bad++;
         $display("FAIL reset_mid_rotate: got e=%b ac=%h busy=%b done=%b want all 0", e_out, ac_out, busy_out, done_out);
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done_out !== 1'b0 || busy_out !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_quiet: got spurious done/busy=%b want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_ac [3];
      logic [3:0]  ops [3];
      ops[0] = 4'd3; ops[1] = 4'd11; ops[2] = 4'd5;
      exp_ac[0] = 16'h00FF; exp_ac[1] = 16'h0100; exp_ac[2] = 16'hFEFF;
      @(negedge clk);
      dr_in = 16'h00FF; count_in = '0;
      for (int i = 0; i < 3; i++) begin
         op_in = ops[i]; start_in = 1'b1;
         @(negedge clk);
         total++;
         if (ac_out !== exp_ac[i] || done_out !== 1'b1 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b[%0d]: got ac=%h done=%b busy=%b want %h 1 0", i, ac_out, done_out, busy_out, exp_ac[i]);
         end
      end
      start_in = 1'b0;
      @(negedge clk);
      total++;
      if (done_out !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: got done=%b want 0", done_out);
      end
   endtask

   task automatic test_random();
      int lat, bn, exp_lat, errs;
      logic da;
      logic [16:0] m;
      logic [3:0] op;
      logic [15:0] dr;
      logic [7:0] inpr;
      logic [4:0] cnt;
      run_cmd(4'd8, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      run_cmd(4'd9, 16'h0000, 8'h00, 5'd0, lat, bn, da);
      m = 17'b0;
      errs = 0;
      for (int i = 0; i < 150; i++) begin
         op   = 4'($urandom_range(0, 15));
         dr   = 16'($urandom);
         inpr = 8'($urandom);
         cnt  = 5'($urandom_range(0, 31));
         run_cmd(op, dr, inpr, cnt, lat, bn, da);
         m = model(op, dr, inpr, int'(cnt), m);
         exp_lat = ((op == 4'd12 || op == 4'd13) && cnt != 0) ? int'(cnt) + 1 : 1;
         total++;
         if ({e_out, ac_out} !== m || lat != exp_lat || bn != exp_lat - 1 || da !== 1'b0) begin
            bad++;
            errs++;
            if (errs < 10)
               $display("FAIL rand[%0d] op=%0d cnt=%0d: got e_ac=%h lat=%0d busy=%0d after=%b want %h %0d %0d 0",
                        i, op, cnt, {e_out, ac_out}, lat, bn, da, m, exp_lat, exp_lat - 1);
         end
      end
   endtask

   task automatic test_small_width();
      s_cmd(4'd4, 8'h00, 4'hA);
      total++;
      if (s_ac !== 8'h0A || s_done !== 1'b1) begin
         bad++;
         $display("FAIL small_inp: got ac=%h done=%b want 0a 1", s_ac, s_done);
      end
      s_cmd(4'd10, 8'h00, 4'h0);
      s_cmd(4'd3, 8'hFF, 4'h0);
`ifdef ACCUMULATOR_FLAGS_EN
      total++;
      if (s_zero !== 1'b0 || s_neg !== 1'b1) begin
         bad++;
         $display("FAIL small_flags_ff: got zero=%b neg=%b want 0 1", s_zero, s_neg);
      end
`endif
      s_cmd(4'd11, 8'h00, 4'h0);
      total++;
      if (s_ac !== 8'h00 || s_e !== 1'b1) begin
         bad++;
         $display("FAIL small_inc_wrap: got ac=%h e=%b want 00 1", s_ac, s_e);
      end
`ifdef ACCUMULATOR_FLAGS_EN
      total++;
      if (s_zero !== 1'b1 || s_neg !== 1'b0) begin
         bad++;
         $display("FAIL small_flags_zero: got zero=%b neg=%b want 1 0", s_zero, s_neg);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_lda_add();
      test_cir_cil();
      test_rotate_n();
      test_rotate_wrap();
      test_reset_mid_rotate();
      test_back_to_back();
      test_random();
      test_small_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
